list_walker: RTL and testbench

- Parametrised linked-list traversal engine: holds an N-entry next-pointer table and, per accepted start pointer, emits every node of that list in order on a valid/ready output stream.
- Pointer 0 is the null terminator.
- Extends the fixed 16-node sequencer with runtime table writes, output backpressure, selectable gap/no-gap list chaining, per-element index, last-flag and cycle (loop) detection.
- Sits between the list-head request source and downstream pointer consumers.

---
 rtl/list_walker.sv | 85 ++++++++
 tb/tb_list_walker.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/list_walker.sv
// Linked-list traversal engine: walks a runtime-writable next-pointer table from
// each accepted head and streams every node (index, tail flag, loop-guard error).
module list_walker #(
  parameter int N = 16,
  parameter bit NO_GAP = 1'b0,
  localparam int W = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         wr_en,
  input  logic [W-1:0] wr_ptr,
  input  logic [W-1:0] wr_next,
  input  logic         start_vld,
  input  logic [W-1:0] start,
  output logic         start_rdy,
  output logic         out_vld,
  input  logic         out_rdy,
  output logic [W-1:0] out_ptr,
  output logic [W-1:0] out_idx,
  output logic         out_last,
  output logic         out_err,
  output logic         busy
);

  localparam logic [W-1:0] IDX_MAX = W'(N - 2);

  logic [W-1:0] next_q [N];
  logic         out_vld_q, out_vld_d;
  logic [W-1:0] out_ptr_q, out_ptr_d;
  logic [W-1:0] out_idx_q, out_idx_d;
  logic [W-1:0] nxt;
  logic         guard, term, adv, accept;

  // Table has no reset: contents survive rst and a same-cycle read sees the old value.
  always_ff @(posedge clk) begin
    if (wr_en) next_q[wr_ptr] <= wr_next;
  end

  always_comb begin
    nxt       = out_vld_q ? next_q[out_ptr_q] : '0;
    guard     = out_vld_q && (out_idx_q == IDX_MAX) && (nxt != '0);
    term      = out_vld_q && ((nxt == '0) || guard);
    adv       = !out_vld_q || out_rdy;
    start_rdy = NO_GAP ? (adv && (!out_vld_q || term)) : (adv && !out_vld_q);
    accept    = start_vld && start_rdy;

    out_vld_d = out_vld_q;
    out_ptr_d = out_ptr_q;
    out_idx_d = out_idx_q;
    if (adv) begin
      if (out_vld_q && !term) begin
        out_ptr_d = nxt;
        out_idx_d = out_idx_q + 1'b1;
        out_vld_d = 1'b1;
      end else if (accept) begin
        // A null head is consumed silently and produces no element.
        out_ptr_d = start;
        out_idx_d = '0;
        out_vld_d = (start != '0);
      end else begin
        out_vld_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_vld_q <= 1'b0;
      out_ptr_q <= '0;
      out_idx_q <= '0;
    end else begin
      out_vld_q <= out_vld_d;
      out_ptr_q <= out_ptr_d;
      out_idx_q <= out_idx_d;
    end
  end

  assign out_vld  = out_vld_q;
  assign out_ptr  = out_ptr_q;
  assign out_idx  = out_idx_q;
  assign out_last = term;
  assign out_err  = guard;
  assign busy     = out_vld_q;

endmodule

// File: tb/tb_list_walker.sv
// Bench for list_walker: directed scenarios on a gap and a no-gap instance, then
// random heads/backpressure checked against a list-walking reference model.
module tb_list_walker;

  logic       clk, rst;
  logic       wr_en;
  logic [3:0] wr_ptr, wr_next;
  logic       sv [2];
  logic [3:0] st [2];
  logic       srdy [2];
  logic       ov [2];
  logic       ordy [2];
  logic [3:0] op [2];
  logic [3:0] oi [2];
  logic       ol [2];
  logic       oe [2];
  logic       bsy [2];

  int total = 0;
  int bad = 0;
  logic [3:0] tbl [16];
  int q0 [$];
  int q1 [$];
  bit mon_en = 1'b0;
  bit pv [2] = '{1'b0, 1'b0};
  bit pr [2];
  logic [31:0] pdat [2];

  list_walker #(.N(16), .NO_GAP(1'b0)) dut0 (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_ptr(wr_ptr), .wr_next(wr_next),
    .start_vld(sv[0]), .start(st[0]), .start_rdy(srdy[0]),
    .out_vld(ov[0]), .out_rdy(ordy[0]), .out_ptr(op[0]), .out_idx(oi[0]),
    .out_last(ol[0]), .out_err(oe[0]), .busy(bsy[0])
  );

  list_walker #(.N(16), .NO_GAP(1'b1)) dut1 (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_ptr(wr_ptr), .wr_next(wr_next),
    .start_vld(sv[1]), .start(st[1]), .start_rdy(srdy[1]),
    .out_vld(ov[1]), .out_rdy(ordy[1]), .out_ptr(op[1]), .out_idx(oi[1]),
    .out_last(ol[1]), .out_err(oe[1]), .busy(bsy[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL timeout: total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Packed as {vld, err, last, idx, ptr}.
  task automatic chk_out(input string tag, input int k, input bit v, input int p,
                         input int i, input bit l, input bit e);
    chk(tag, {22'd0, ov[k], oe[k], ol[k], oi[k], op[k]},
        {22'd0, v, e, l, 4'(i), 4'(p)});
  endtask

  // Reference: follow the table from the head; at most N-1 nodes, flagged if still going.
  function automatic void push_list(input int k, input logic [3:0] s);
    int p, n, idx, v;
    bit last, err;
    p = int'(s);
    idx = 0;
    while (p != 0) begin
      n = int'(tbl[p]);
      err = (n != 0) && (idx == 14);
      last = (n == 0) || err;
      v = (int'(err) << 9) | (int'(last) << 8) | (idx << 4) | p;
      if (k == 0) q0.push_back(v); else q1.push_back(v);
      if (last) break;
      p = n;
      idx++;
    end
  endfunction

  function automatic int pop(input int k);
    if (k == 0) return (q0.size() == 0) ? -1 : q0.pop_front();
    return (q1.size() == 0) ? -1 : q1.pop_front();
  endfunction

  always @(negedge clk) begin
    if (mon_en && !rst) begin
      for (int k = 0; k < 2; k++) begin
        if (pv[k] && !pr[k])
          chk($sformatf("hold%0d", k), {23'd0, ov[k], op[k], oi[k]}, pdat[k]);
        if (ov[k] && ordy[k])
          chk($sformatf("stream%0d", k), {22'd0, oe[k], ol[k], oi[k], op[k]}, pop(k));
        if (sv[k] && srdy[k]) push_list(k, st[k]);
        pv[k] <= ov[k];
        pr[k] <= ordy[k];
        pdat[k] <= {23'd0, ov[k], op[k], oi[k]};
      end
    end else begin
      pv[0] <= 1'b0;
      pv[1] <= 1'b0;
    end
  end

  task automatic sm();
    @(negedge clk);
  endtask

  task automatic nx();
    @(posedge clk);
    #1;
  endtask

  task automatic do_wr(input int p, input int n);
    wr_en = 1'b1;
    wr_ptr = 4'(p);
    wr_next = 4'(n);
    tbl[p] = 4'(n);
    nx();
    wr_en = 1'b0;
  endtask

  initial begin
    logic [3:0] init_t [16];
    logic [3:0] heads [2];
    int acc [2];
    int e0p [8], e0i [8], e1p [7], e1i [7];
    bit e0v [8], e0l [8], e0r [8], e1l [7], e1r [7];
    int p;

    init_t = '{4'd0, 4'd5, 4'd4, 4'd10, 4'd2, 4'd3, 4'd0, 4'd15,
               4'd0, 4'd14, 4'd0, 4'd13, 4'd0, 4'd12, 4'd11, 4'd8};
    heads = '{4'd7, 4'd1};
    e0p = '{7, 15, 8, 0, 1, 5, 3, 10};
    e0i = '{0, 1, 2, 0, 0, 1, 2, 3};
    e0v = '{1, 1, 1, 0, 1, 1, 1, 1};
    e0l = '{0, 0, 1, 0, 0, 0, 0, 1};
    e0r = '{0, 0, 0, 1, 0, 0, 0, 0};
    e1p = '{7, 15, 8, 1, 5, 3, 10};
    e1i = '{0, 1, 2, 0, 1, 2, 3};
    e1l = '{0, 0, 1, 0, 0, 0, 1};
    e1r = '{0, 0, 1, 0, 0, 0, 1};

    rst = 1'b1;
    wr_en = 1'b0; wr_ptr = '0; wr_next = '0;
    for (int k = 0; k < 2; k++) begin sv[k] = 1'b0; st[k] = '0; ordy[k] = 1'b1; end
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 16; i++) do_wr(i, int'(init_t[i]));
    rst = 1'b0;
    sm();
    chk_out("reset0", 0, 0, 0, 0, 0, 0);
    chk_out("reset1", 1, 0, 0, 0, 0, 0);
    nx();

    // Two lists back to back: gap instance vs no-gap instance.
    acc = '{0, 0};
    for (int c = 0; c < 10; c++) begin
      for (int k = 0; k < 2; k++) begin
        sv[k] = (acc[k] < 2);
        st[k] = (acc[k] < 2) ? heads[acc[k]] : 4'd0;
      end
      sm();
      if (c == 0) begin
        chk("srdy_idle0", {31'd0, srdy[0]}, 1);
        chk("srdy_idle1", {31'd0, srdy[1]}, 1);
      end else begin
        p = c - 1;
        if (p < 8) begin
          chk($sformatf("gap_vld[%0d]", p), {31'd0, ov[0]}, {31'd0, e0v[p]});
          chk($sformatf("gap_srdy[%0d]", p), {31'd0, srdy[0]}, {31'd0, e0r[p]});
          if (e0v[p]) chk_out($sformatf("gap_out[%0d]", p), 0, 1, e0p[p], e0i[p], e0l[p], 0);
        end else begin
          chk("gap_end", {31'd0, ov[0]}, 0);
        end
        if (p < 7) begin
          chk_out($sformatf("nogap_out[%0d]", p), 1, 1, e1p[p], e1i[p], e1l[p], 0);
          chk($sformatf("nogap_srdy[%0d]", p), {31'd0, srdy[1]}, {31'd0, e1r[p]});
        end else begin
          chk("nogap_end", {31'd0, ov[1]}, 0);
          chk("nogap_busy", {31'd0, bsy[1]}, 0);
        end
      end
      for (int k = 0; k < 2; k++) if (sv[k] && srdy[k]) acc[k]++;
      nx();
    end
    sv[0] = 1'b0; sv[1] = 1'b0;
    nx();

    // Backpressure on 9->14->11->13->12.
    sv[0] = 1'b1; st[0] = 4'd9;
    sm(); chk("bp_srdy", {31'd0, srdy[0]}, 1); nx();
    sv[0] = 1'b0;
    sm(); chk_out("bp_9", 0, 1, 9, 0, 0, 0); nx();
    ordy[0] = 1'b0;
    for (int i = 0; i < 3; i++) begin
      sm();
      chk_out($sformatf("bp_hold%0d", i), 0, 1, 14, 1, 0, 0);
      chk("bp_srdy_low", {31'd0, srdy[0]}, 0);
      nx();
    end
    ordy[0] = 1'b1;
    sm(); chk_out("bp_14", 0, 1, 14, 1, 0, 0); nx();
    sm(); chk_out("bp_11", 0, 1, 11, 2, 0, 0); nx();
    sm(); chk_out("bp_13", 0, 1, 13, 3, 0, 0); nx();
    sm(); chk_out("bp_12", 0, 1, 12, 4, 1, 0); nx();
    sm(); chk("bp_end", {31'd0, ov[0]}, 0); nx();

    // Loop 2->4->2: truncated after 15 elements.
    sv[0] = 1'b1; st[0] = 4'd2; nx(); sv[0] = 1'b0;
    for (int i = 0; i < 15; i++) begin
      sm();
      chk_out($sformatf("loop[%0d]", i), 0, 1, (i % 2 == 1) ? 4 : 2, i, i == 14, i == 14);
      chk("loop_busy", {31'd0, bsy[0]}, 1);
      nx();
    end
    sm(); chk("loop_end", {31'd0, ov[0]}, 0); nx();

    // Null head, then single-node list.
    sv[0] = 1'b1; st[0] = 4'd0;
    sm(); chk("null_srdy", {31'd0, srdy[0]}, 1); nx();
    sv[0] = 1'b0;
    sm(); chk("null_novld", {31'd0, ov[0]}, 0); nx();
    sv[0] = 1'b1; st[0] = 4'd6; nx(); sv[0] = 1'b0;
    sm(); chk_out("single6", 0, 1, 6, 0, 1, 0); nx();
    sm(); chk("single_end", {31'd0, ov[0]}, 0); nx();

    // Table write mid-walk cuts the list at 3.
    sv[0] = 1'b1; st[0] = 4'd1; nx(); sv[0] = 1'b0;
    sm(); chk_out("wr_1", 0, 1, 1, 0, 0, 0); nx();
    wr_en = 1'b1; wr_ptr = 4'd3; wr_next = 4'd0; tbl[3] = 4'd0;
    sm(); chk_out("wr_5", 0, 1, 5, 1, 0, 0); nx();
    wr_en = 1'b0;
    sm(); chk_out("wr_3last", 0, 1, 3, 2, 1, 0); nx();
    sm(); chk("wr_end", {31'd0, ov[0]}, 0); nx();
    do_wr(3, 10);

    // Reset mid-list, then restart from the retained table.
    sv[0] = 1'b1; st[0] = 4'd1; nx(); sv[0] = 1'b0;
    sm(); chk_out("rs_1", 0, 1, 1, 0, 0, 0); nx();
    sm(); chk_out("rs_5", 0, 1, 5, 1, 0, 0);
    rst = 1'b1;
    #1;
    chk_out("rs_mid", 0, 0, 0, 0, 0, 0);
    nx();
    rst = 1'b0;
    sv[0] = 1'b1; st[0] = 4'd1;
    sm(); chk("rs_srdy", {31'd0, srdy[0]}, 1); nx();
    sv[0] = 1'b0;
    sm(); chk_out("rs_r1", 0, 1, 1, 0, 0, 0); nx();
    sm(); chk_out("rs_r5", 0, 1, 5, 1, 0, 0); nx();
    sm(); chk_out("rs_r3", 0, 1, 3, 2, 0, 0); nx();
    sm(); chk_out("rs_r10", 0, 1, 10, 3, 1, 0); nx();

    // Random tables (loops likely), random heads and backpressure.
    for (int r = 0; r < 3; r++) begin
      for (int i = 1; i < 16; i++) do_wr(i, int'($urandom_range(0, 15)));
      mon_en = 1'b1;
      repeat (300) begin
        for (int k = 0; k < 2; k++) begin
          sv[k] = ($urandom_range(0, 2) == 0);
          st[k] = 4'($urandom_range(0, 15));
          ordy[k] = ($urandom_range(0, 3) != 0);
        end
        nx();
      end
      sv[0] = 1'b0; sv[1] = 1'b0; ordy[0] = 1'b1; ordy[1] = 1'b1;
      repeat (40) nx();
      mon_en = 1'b0;
      chk($sformatf("drain0_r%0d", r), q0.size(), 0);
      chk($sformatf("drain1_r%0d", r), q1.size(), 0);
      q0.delete();
      q1.delete();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
